// File: rtl/irb_pkg.sv
// Shared types and sizing for the kernel-weight tile buffer controller.
// Tile depth, weight width and parallelism are set here and used by every file.
package irb_pkg;

  localparam int KPW_N_ELEM = 8;
  localparam int WG_W       = 8;
  localparam int Npar       = 4;

  localparam int KPW_AW = $clog2(KPW_N_ELEM);
  localparam int KPW_LW = KPW_AW + 1;
  localparam int KPW_DW = WG_W + $clog2(Npar);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    LOADED,
    READ
  } kpw_state_t;

  // Requested lengths beyond the RAM depth are clamped to a full tile.
  function automatic logic [KPW_LW-1:0] clamp_len(input logic [KPW_LW-1:0] n);
    return (n > KPW_LW'(KPW_N_ELEM)) ? KPW_LW'(KPW_N_ELEM) : n;
  endfunction

endpackage

// File: rtl/kpw_ctrl_if.sv
// Load/read stream bundle between the tile producer/consumer and kpw_ctrl.
// The master drives starts and load data; the slave (kpw_ctrl) drives status and read data.
interface kpw_ctrl_if;
  import irb_pkg::*;

  logic              ld_start;
  logic [KPW_LW-1:0] n_elem;
  logic              ld_valid;
  logic [KPW_DW-1:0] ld_data;
  logic              ld_ready;
  logic              ld_done;
  logic              rd_start;
  logic              rd_stall;
  logic              rd_valid;
  logic [KPW_DW-1:0] rd_data;
  logic              rd_last;
  logic              busy;

  modport master (
    output ld_start, n_elem, ld_valid, ld_data, rd_start, rd_stall,
    input  ld_ready, ld_done, rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    input  ld_start, n_elem, ld_valid, ld_data, rd_start, rd_stall,
    output ld_ready, ld_done, rd_valid, rd_data, rd_last, busy
  );

endinterface

// File: rtl/kpw_ctrl_ram.sv
// Single-port tile RAM with a registered, enable-gated read port (1-cycle latency).
// The read register holds its word while re is low, which is what lets a stalled beat stay put.
module RAM_KPW
  import irb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic [KPW_AW-1:0] addr,
  input  logic [KPW_DW-1:0] wdata,
  output logic [KPW_DW-1:0] rdata
);

  logic [KPW_DW-1:0] mem_q [KPW_N_ELEM];
  logic [KPW_DW-1:0] rdata_q;

  // NOTE: the array has no reset; clearing it would force flops instead of RAM.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/kpw_ctrl.sv
// Tile buffer controller: loads a tile of weight words into RAM_KPW, then streams
// it out (repeatedly if asked) to the PW datapath with consumer back-pressure.
module kpw_ctrl
  import irb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  kpw_ctrl_if.slave  bus
);

  kpw_state_t        state_q;
  logic              loaded_q;
  logic [KPW_AW-1:0] wr_cnt_q;
  logic [KPW_AW-1:0] rd_cnt_q;
  logic [KPW_LW-1:0] len_q;
  logic              ld_ready_q;
  logic              ld_done_q;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic              busy_q;

  logic [KPW_AW-1:0] last_addr;
  logic              ram_we;
  logic              ram_re;
  logic [KPW_AW-1:0] ram_addr;
  logic [KPW_DW-1:0] ram_rdata;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    last_addr = KPW_AW'(len_q - KPW_LW'(1));
    ram_we    = (state_q == LOAD) && bus.ld_valid;
    // Stop issuing once the last word is on the output; it only has to drain.
    ram_re    = (state_q == READ) && !bus.rd_stall && !(rd_valid_q && rd_last_q);
    ram_addr  = (state_q == LOAD) ? wr_cnt_q : rd_cnt_q;
  end

  RAM_KPW u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (bus.ld_data),
    .rdata (ram_rdata)
  );

  // NOTE: sequential state uses <= so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      loaded_q   <= 1'b0;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      len_q      <= '0;
      ld_ready_q <= 1'b0;
      ld_done_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      ld_done_q <= 1'b0;
      case (state_q)
        IDLE, LOADED: begin
          // A read request outranks a simultaneous reload of the tile.
          if (state_q == LOADED && loaded_q && bus.rd_start) begin
            state_q  <= READ;
            rd_cnt_q <= '0;
            busy_q   <= 1'b1;
          end else if (bus.ld_start && bus.n_elem != '0) begin
            state_q    <= LOAD;
            len_q      <= clamp_len(bus.n_elem);
            wr_cnt_q   <= '0;
            ld_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end
        LOAD: begin
          if (bus.ld_valid) begin
            if (wr_cnt_q == last_addr) begin
              state_q    <= LOADED;
              loaded_q   <= 1'b1;
              ld_done_q  <= 1'b1;
              ld_ready_q <= 1'b0;
              busy_q     <= 1'b0;
            end else begin
              wr_cnt_q <= wr_cnt_q + KPW_AW'(1);
            end
          end
        end
        READ: begin
          if (!bus.rd_stall) begin
            if (rd_valid_q && rd_last_q) begin
              rd_valid_q <= 1'b0;
              rd_last_q  <= 1'b0;
              state_q    <= LOADED;
              busy_q     <= 1'b0;
            end else begin
              rd_valid_q <= 1'b1;
              rd_last_q  <= (rd_cnt_q == last_addr);
              if (rd_cnt_q != last_addr) rd_cnt_q <= rd_cnt_q + KPW_AW'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ld_ready = ld_ready_q;
  assign bus.ld_done  = ld_done_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = ram_rdata;
  assign bus.rd_last  = rd_last_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_kpw_ctrl.sv
// Scoreboard bench for kpw_ctrl: directed loads/reads push expected beats into a
// queue; a negedge monitor pops and compares every consumed read beat.
module tb_kpw_ctrl;
  import irb_pkg::*;

  typedef struct {
    logic [KPW_DW-1:0] data;
    logic              last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  kpw_ctrl_if bus_if ();

  kpw_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  beat_t exp_q[$];
  int    pass_cnt   = 0;
  int    tot_cnt    = 0;
  int    beats_seen = 0;
  int    done_cnt   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [KPW_DW-1:0] d, input logic l);
    beat_t b;
    b.data = d;
    b.last = l;
    exp_q.push_back(b);
  endtask

  task automatic pulse_rd();
    bus_if.rd_start = 1'b1;
    step();
    bus_if.rd_start = 1'b0;
  endtask

  task automatic start_load(input int n);
    bus_if.ld_start = 1'b1;
    bus_if.n_elem   = KPW_LW'(n);
    step();
    bus_if.ld_start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 60; i++) begin
      if (!bus_if.busy && exp_q.size() == 0) break;
      step();
    end
    check({name, "_busy"}, 32'(bus_if.busy), 32'd0);
    check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compare every beat the consumer actually takes.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.ld_done) done_cnt++;
      if (bus_if.rd_valid && !bus_if.rd_stall) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 32'(bus_if.rd_data), 32'hdead);
        end else begin
          beat_t b;
          b = exp_q.pop_front();
          check("rd_data", 32'(bus_if.rd_data), 32'(b.data));
          check("rd_last", 32'(bus_if.rd_last), 32'(b.last));
        end
      end
    end
  end

  logic [KPW_DW-1:0] words [4];
  logic [KPW_DW-1:0] gap_d [5];
  logic              gap_v [5];
  int                seen0;

  initial begin
    words = '{10'h00A, 10'h00B, 10'h00C, 10'h00D};
    gap_d = '{10'h011, 10'h3FF, 10'h022, 10'h3FF, 10'h033};
    gap_v = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    bus_if.ld_start = 1'b0;
    bus_if.n_elem   = '0;
    bus_if.ld_valid = 1'b0;
    bus_if.ld_data  = '0;
    bus_if.rd_start = 1'b0;
    bus_if.rd_stall = 1'b0;
    step(2);
    rst = 1'b0;
    step();

    // Reset state
    check("rst_ld_ready", 32'(bus_if.ld_ready), 32'd0);
    check("rst_ld_done",  32'(bus_if.ld_done),  32'd0);
    check("rst_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    check("rst_rd_last",  32'(bus_if.rd_last),  32'd0);
    check("rst_busy",     32'(bus_if.busy),     32'd0);
    check("rst_rd_data",  32'(bus_if.rd_data),  32'd0);

    // Illegal starts from IDLE
    pulse_rd();
    step(4);
    check("idle_rd_ignored", 32'(beats_seen), 32'd0);
    start_load(0);
    step();
    check("zero_len_ready", 32'(bus_if.ld_ready), 32'd0);
    check("zero_len_state", 32'(dut.state_q), 32'(IDLE));

    // Full load of four words, valid every cycle
    start_load(4);
    check("load_ready", 32'(bus_if.ld_ready), 32'd1);
    check("load_busy",  32'(bus_if.busy),     32'd1);
    for (int i = 0; i < 4; i++) begin
      bus_if.ld_valid = 1'b1;
      bus_if.ld_data  = words[i];
      step();
      check("full_ld_done", 32'(bus_if.ld_done), 32'(i == 3));
    end
    bus_if.ld_valid = 1'b0;
    check("full_ready_off", 32'(bus_if.ld_ready), 32'd0);
    check("full_state", 32'(dut.state_q), 32'(LOADED));
    step();
    check("full_done_pulse", 32'(bus_if.ld_done), 32'd0);
    check("full_done_cnt", 32'(done_cnt), 32'd1);

    // Read with a two-cycle stall on the second beat
    for (int i = 0; i < 4; i++) push(words[i], i == 3);
    pulse_rd();
    for (int i = 0; i < 10; i++) begin
      if (bus_if.rd_valid) break;
      step();
    end
    check("first_beat_data", 32'(bus_if.rd_data), 32'h00A);
    step();
    bus_if.rd_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("stall_valid", 32'(bus_if.rd_valid), 32'd1);
      check("stall_data",  32'(bus_if.rd_data),  32'h00B);
      check("stall_last",  32'(bus_if.rd_last),  32'd0);
      step();
    end
    check("stall_end_data", 32'(bus_if.rd_data), 32'h00B);
    bus_if.rd_stall = 1'b0;
    wait_idle("stall_read");
    check("stall_read_state", 32'(dut.state_q), 32'(LOADED));

    // ld_start in the middle of a read is ignored
    for (int i = 0; i < 4; i++) push(words[i], i == 3);
    pulse_rd();
    step();
    start_load(2);
    check("midread_ready", 32'(bus_if.ld_ready), 32'd0);
    wait_idle("midread");
    check("midread_state", 32'(dut.state_q), 32'(LOADED));

    // Simultaneous ld_start and rd_start: read wins, tile unchanged
    for (int i = 0; i < 4; i++) push(words[i], i == 3);
    bus_if.ld_start = 1'b1;
    bus_if.n_elem   = KPW_LW'(2);
    bus_if.rd_start = 1'b1;
    step();
    bus_if.ld_start = 1'b0;
    bus_if.rd_start = 1'b0;
    check("simul_ready", 32'(bus_if.ld_ready), 32'd0);
    check("simul_state", 32'(dut.state_q), 32'(READ));
    wait_idle("simul");

    // Gapped load of three words
    start_load(3);
    for (int i = 0; i < 5; i++) begin
      bus_if.ld_valid = gap_v[i];
      bus_if.ld_data  = gap_d[i];
      step();
      check("gap_ld_done", 32'(bus_if.ld_done), 32'(i == 4));
    end
    bus_if.ld_valid = 1'b0;
    push(10'h011, 1'b0);
    push(10'h022, 1'b0);
    push(10'h033, 1'b1);
    pulse_rd();
    wait_idle("gap_read");

    // Oversized request clamps to a full tile
    start_load(15);
    for (int i = 0; i < KPW_N_ELEM; i++) begin
      bus_if.ld_valid = 1'b1;
      bus_if.ld_data  = KPW_DW'(10'h100 + i);
      step();
      check("clamp_ld_done", 32'(bus_if.ld_done), 32'(i == KPW_N_ELEM - 1));
    end
    bus_if.ld_valid = 1'b0;
    for (int i = 0; i < KPW_N_ELEM; i++) push(KPW_DW'(10'h100 + i), i == KPW_N_ELEM - 1);
    pulse_rd();
    wait_idle("clamp_read");
    check("done_cnt_before_abort", 32'(done_cnt), 32'd3);

    // Reset on the second load word aborts the load
    start_load(4);
    bus_if.ld_valid = 1'b1;
    bus_if.ld_data  = 10'h2AA;
    step();
    bus_if.ld_data  = 10'h155;
    rst = 1'b1;
    step();
    check("abort_ready", 32'(bus_if.ld_ready), 32'd0);
    check("abort_busy",  32'(bus_if.busy),     32'd0);
    rst = 1'b0;
    bus_if.ld_valid = 1'b0;
    step(3);
    check("abort_no_done", 32'(done_cnt), 32'd3);
    seen0 = beats_seen;
    pulse_rd();
    step(5);
    check("abort_rd_ignored", 32'(beats_seen), 32'(seen0));
    check("abort_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    check("final_queue", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
